// File: rtl/caregiver_pkg.sv
// Shared definitions for the caregiver responder and the action regulator:
// one-hot action codes, stimulus bit indices, FSM state encoding, LFSR seed,
// and the action-to-stimulus lookup used at capture time.
package caregiver_pkg;

  localparam int ACT_W  = 8;
  localparam int STIM_W = 5;

  // One-hot action codes emitted by the action regulator.
  localparam logic [ACT_W-1:0] ACT_SLEEP     = 8'h01;
  localparam logic [ACT_W-1:0] ACT_EAT       = 8'h02;
  localparam logic [ACT_W-1:0] ACT_PLAY      = 8'h04;
  localparam logic [ACT_W-1:0] ACT_SMILE     = 8'h08;
  localparam logic [ACT_W-1:0] ACT_BABBLE    = 8'h10;
  localparam logic [ACT_W-1:0] ACT_KICK_LEGS = 8'h20;
  localparam logic [ACT_W-1:0] ACT_IDLE      = 8'h40;
  localparam logic [ACT_W-1:0] ACT_CRY       = 8'h80;

  // Stimulus bit positions fed back into the regulator.
  localparam int STIM_TICKLE    = 0;
  localparam int STIM_PLAY_WITH = 1;
  localparam int STIM_TALK_TO   = 2;
  localparam int STIM_CALM_DOWN = 3;
  localparam int STIM_FEED      = 4;

  // Reset value of the optional reaction-jitter LFSR.
  localparam logic [7:0] LFSR_SEED = 8'hA5;

  typedef enum logic [1:0] {
    ST_WATCH    = 2'd0,
    ST_WAIT     = 2'd1,
    ST_PULSE    = 2'd2,
    ST_COOLDOWN = 2'd3
  } cg_state_e;

  // True when exactly one bit of the action vector is set.
  function automatic logic is_onehot(input logic [ACT_W-1:0] act);
    return (act != '0) && ((act & (act - 8'd1)) == '0);
  endfunction

  // Stimulus answering a given action; zero means "no response".
  // CRY alternates calm_down / feed on the parity of the cry streak.
  function automatic logic [STIM_W-1:0] resp_lookup(input logic [ACT_W-1:0] act,
                                                    input logic            cry_odd);
    logic [STIM_W-1:0] r;
    r = '0;
    case (act)
      ACT_SMILE:            r[STIM_TICKLE]    = 1'b1;
      ACT_KICK_LEGS:        r[STIM_PLAY_WITH] = 1'b1;
      ACT_BABBLE, ACT_IDLE: r[STIM_TALK_TO]   = 1'b1;
      ACT_CRY: begin
        if (cry_odd) r[STIM_FEED]      = 1'b1;
        else         r[STIM_CALM_DOWN] = 1'b1;
      end
      default:              r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/caregiver_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5) supplying 0..3 cycles of reaction jitter.
// Ports: clk, rst_n (sync, active-low), jit_o = two low LFSR bits. Only built with CAREGIVER_JITTER_EN.
// Advances every cycle; no backpressure.
module caregiver_lfsr
  import caregiver_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output logic [1:0] jit_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // Shift toward the MSB, feedback from taps 8,6,5,4 (bits 7,5,4,3).
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_ff @(posedge clk) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign jit_o = lfsr_q[1:0];

endmodule

// File: rtl/caregiver_responder.sv
// Caregiver model: watches the one-hot action vector and answers with timed stimulus pulses.
// Ports: clk, rst_n (sync, active-low), action[7:0], enable -> stimuli_out[4:0], busy,
//        response_count[7:0] (saturating), onehot_err (sticky). Optional jitter: CAREGIVER_JITTER_EN.
// Latency: capture at edge k -> stimuli_out high after edges k+REACT_DELAY .. k+REACT_DELAY+PULSE_LEN-1.
module caregiver_responder
  import caregiver_pkg::*;
#(
  parameter int DELAY_W      = 4,
  parameter int REACT_DELAY  = 3,
  parameter int PULSE_LEN    = 2,
  parameter int COOLDOWN_LEN = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  action,
  input  logic        enable,
  output logic [4:0]  stimuli_out,
  output logic        busy,
  output logic [7:0]  response_count,
  output logic        onehot_err
);

  localparam int CNT_MAX = (1 << DELAY_W) - 1;

  // Every timing parameter has to fit the shared counter.
  if (DELAY_W < 1 || DELAY_W > 16) begin : g_bad_width
    $error("caregiver_responder: DELAY_W must be 1..16");
  end
  if (REACT_DELAY < 0 || REACT_DELAY > CNT_MAX) begin : g_bad_react
    $error("caregiver_responder: REACT_DELAY exceeds counter range");
  end
  if (PULSE_LEN < 1 || PULSE_LEN > CNT_MAX) begin : g_bad_pulse
    $error("caregiver_responder: PULSE_LEN must be 1..2^DELAY_W-1");
  end
  if (COOLDOWN_LEN < 0 || COOLDOWN_LEN > CNT_MAX) begin : g_bad_cool
    $error("caregiver_responder: COOLDOWN_LEN exceeds counter range");
  end

  localparam logic [DELAY_W-1:0] REACT_C = DELAY_W'(REACT_DELAY);
  localparam logic [DELAY_W-1:0] PULSE_C = DELAY_W'(PULSE_LEN);
  localparam logic [DELAY_W-1:0] COOL_C  = DELAY_W'(COOLDOWN_LEN);
  localparam logic [DELAY_W-1:0] CNT_ONE = DELAY_W'(1);

  cg_state_e           state_q;
  logic [DELAY_W-1:0]  cnt_q;
  logic [ACT_W-1:0]    cap_action_q;
  logic [STIM_W-1:0]   resp_bit_q;
  logic [STIM_W-1:0]   stim_q;
  logic                cry_odd_q;      // parity of the cry streak; only the LSB picks the response
  logic [7:0]          resp_cnt_q;
  logic                onehot_err_q;

  logic                act_valid;
  logic                is_cry;
  logic [STIM_W-1:0]   resp_now;
  logic                capture;
  logic [DELAY_W-1:0]  delay_load;
  logic [7:0]          resp_cnt_d;

  assign act_valid = is_onehot(action);
  assign is_cry    = (action == ACT_CRY);
  assign resp_now  = resp_lookup(action, cry_odd_q);
  // Actions without a response (SLEEP/EAT/PLAY) are never captured.
  assign capture   = enable && act_valid && (resp_now != '0);
  assign resp_cnt_d = (resp_cnt_q == 8'hFF) ? resp_cnt_q : resp_cnt_q + 8'd1;

`ifdef CAREGIVER_JITTER_EN
  logic [1:0]         jit;
  logic [DELAY_W:0]   jit_sum;

  caregiver_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .jit_o (jit)
  );

  // Extra 0..3 cycles of reaction time, clamped to the counter maximum.
  assign jit_sum    = (DELAY_W+1)'(REACT_DELAY) + (DELAY_W+1)'(jit);
  assign delay_load = (jit_sum > (DELAY_W+1)'(CNT_MAX)) ? '1 : jit_sum[DELAY_W-1:0];
`else
  assign delay_load = REACT_C;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_WATCH;
      cnt_q        <= '0;
      cap_action_q <= '0;
      resp_bit_q   <= '0;
      stim_q       <= '0;
      cry_odd_q    <= 1'b0;
      resp_cnt_q   <= '0;
      onehot_err_q <= 1'b0;
    end else begin
      if (!act_valid) onehot_err_q <= 1'b1;

      case (state_q)
        ST_WATCH: begin
          if (capture) begin
            cap_action_q <= action;
            resp_bit_q   <= resp_now;
            if (delay_load == '0) begin
              // Zero reaction time: the pulse starts on the capture edge.
              state_q    <= ST_PULSE;
              stim_q     <= resp_now;
              cnt_q      <= PULSE_C;
              resp_cnt_q <= resp_cnt_d;
              cry_odd_q  <= is_cry ? ~cry_odd_q : 1'b0;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= delay_load;
              if (!is_cry) cry_odd_q <= 1'b0;
            end
          end
        end

        ST_WAIT: begin
          // The caregiver gives up if the baby changes its mind or leaves.
          if (action != cap_action_q || !enable) begin
            state_q <= ST_WATCH;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_ONE) begin
            state_q    <= ST_PULSE;
            stim_q     <= resp_bit_q;
            cnt_q      <= PULSE_C;
            resp_cnt_q <= resp_cnt_d;
            if (cap_action_q == ACT_CRY) cry_odd_q <= ~cry_odd_q;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

        ST_PULSE: begin
          // Runs to completion regardless of enable or action changes.
          if (cnt_q <= CNT_ONE) begin
            stim_q <= '0;
            if (COOL_C == '0) begin
              state_q <= ST_WATCH;
              cnt_q   <= '0;
            end else begin
              state_q <= ST_COOLDOWN;
              cnt_q   <= COOL_C;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

        ST_COOLDOWN: begin
          if (cnt_q <= CNT_ONE) begin
            state_q <= ST_WATCH;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

        default: begin
          state_q <= ST_WATCH;
          stim_q  <= '0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign stimuli_out    = stim_q;
  assign busy           = (state_q != ST_WATCH);
  assign response_count = resp_cnt_q;
  assign onehot_err     = onehot_err_q;

endmodule

// File: tb/tb_caregiver_responder.sv
// Self-checking bench for caregiver_responder: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a timestamp-based behavioural model.
// Define CAREGIVER_JITTER_EN for both bench and RTL to exercise the jitter build.
module tb_caregiver_responder;

  localparam int DW = 4;
  localparam int RD = 3;
  localparam int PL = 2;
  localparam int CL = 4;
`ifdef CAREGIVER_JITTER_EN
  localparam bit JIT = 1'b1;
`else
  localparam bit JIT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] action;
  logic       enable;
  logic [4:0] stimuli_out;
  logic       busy;
  logic [7:0] response_count;
  logic       onehot_err;

  caregiver_responder #(
    .DELAY_W(DW), .REACT_DELAY(RD), .PULSE_LEN(PL), .COOLDOWN_LEN(CL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .action(action), .enable(enable),
    .stimuli_out(stimuli_out), .busy(busy),
    .response_count(response_count), .onehot_err(onehot_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic tmo(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting for DUT (t=%0t)", nm, $time);
  endtask

  // ---------------- behavioural model (edge timestamps) ----------------
  // Capture at edge k with delay D: pulse spans edges s=k+D .. s+PL-1,
  // the next capture is possible at edge s+PL+CL+1; an abort at edge e
  // frees the caregiver from edge e+1.
  int         e_now   = 0;
  int         free_at = 0;
  bit         m_ok    = 0;
  bit         pend;
  int         st_e;
  logic [7:0] cap_act;
  logic [4:0] m_resp;
  int         win_lo, win_hi;
  logic [4:0] win_resp;
  bit         m_cry_odd;
  int         m_count;
  bit         m_err;
  logic [7:0] m_lfsr;
  logic [4:0] exp_stim;
  bit         exp_busy;

  function automatic logic [4:0] m_resp_of(input logic [7:0] a, input bit odd);
    case (a)
      8'h08:        return 5'b00001;
      8'h20:        return 5'b00010;
      8'h10, 8'h40: return 5'b00100;
      8'h80:        return odd ? 5'b10000 : 5'b01000;
      default:      return 5'b00000;
    endcase
  endfunction

  task automatic m_fire(input int e);
    if (m_count < 255) m_count++;
    if (cap_act == 8'h80) m_cry_odd = !m_cry_odd;
    win_lo   = e;
    win_hi   = e + PL - 1;
    win_resp = m_resp;
    free_at  = e + PL + CL + 1;
    pend     = 0;
  endtask

  always @(posedge clk) begin
    int d;
    e_now++;
    if (!rst_n) begin
      m_ok = 1; pend = 0; m_cry_odd = 0; m_count = 0; m_err = 0;
      win_lo = 1; win_hi = 0; free_at = e_now + 1; m_lfsr = 8'hA5;
    end else if (m_ok) begin
      if ($countones(action) != 1) m_err = 1;
      if (pend) begin
        if (action != cap_act || !enable) begin
          pend = 0;
          free_at = e_now + 1;
        end else if (e_now == st_e) begin
          m_fire(e_now);
        end
      end else if (e_now >= free_at && enable && $countones(action) == 1 &&
                   m_resp_of(action, m_cry_odd) != 5'b0) begin
        cap_act = action;
        m_resp  = m_resp_of(action, m_cry_odd);
        if (action != 8'h80) m_cry_odd = 0;
        d = RD + (JIT ? int'(m_lfsr[1:0]) : 0);
        if (d > (1 << DW) - 1) d = (1 << DW) - 1;
        st_e = e_now + d;
        pend = 1;
        if (d == 0) m_fire(e_now);
      end
      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
    exp_stim = (e_now >= win_lo && e_now <= win_hi) ? win_resp : 5'b0;
    exp_busy = pend || (e_now < free_at - 1);
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("m_stim",  32'(stimuli_out),    32'(exp_stim));
      chk("m_busy",  32'(busy),           32'(exp_busy));
      chk("m_count", 32'(response_count), 32'(m_count));
      chk("m_err",   32'(onehot_err),     32'(m_err));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  task automatic wait_pulse(input string nm, output logic [4:0] v);
    int n;
    v = '0;
    n = 0;
    do begin @(negedge clk); n++; end while (stimuli_out == 5'd0 && n < 60);
    if (stimuli_out == 5'd0) begin tmo(nm); return; end
    v = stimuli_out;
    n = 0;
    do begin @(negedge clk); n++; end while (stimuli_out != 5'd0 && n < 20);
    if (stimuli_out != 5'd0) tmo(nm);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 40) begin @(negedge clk); n++; end
    if (busy !== 1'b0) tmo(nm);
  endtask

  initial begin
    logic [4:0] v;
    int n, hold, r, dly, lo, hi;
    rst_n = 1'b0; action = 8'h00; enable = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_stim",  32'(stimuli_out),    0);
    chk("rst_busy",  32'(busy),           0);
    chk("rst_count", 32'(response_count), 0);
    chk("rst_err",   32'(onehot_err),     0);

    // SMILE held: pulses after capture edge k at k+3,k+4 and k+13,k+14; WATCH only after k+9.
    rst_n = 1'b1; action = 8'h08; enable = 1'b1;
    for (int i = 0; i <= 14; i++) begin
      @(negedge clk);
      if (!JIT) begin
        chk($sformatf("smile_stim%0d", i), 32'(stimuli_out),
            (i == 3 || i == 4 || i == 13 || i == 14) ? 32'd1 : 32'd0);
        chk($sformatf("smile_busy%0d", i), 32'(busy), (i == 9) ? 32'd0 : 32'd1);
        if (i == 3)  chk("smile_cnt1", 32'(response_count), 1);
        if (i == 14) chk("smile_cnt2", 32'(response_count), 2);
      end
    end

    // CRY alternation, then IDLE clears the streak.
    action = 8'h80;
    wait_pulse("cry1", v); chk("cry1", 32'(v), 32'b01000);
    wait_pulse("cry2", v); chk("cry2", 32'(v), 32'b10000);
    wait_pulse("cry3", v); chk("cry3", 32'(v), 32'b01000);
    action = 8'h40;
    wait_pulse("idle", v); chk("idle", 32'(v), 32'b00100);
    action = 8'h80;
    wait_pulse("cry_restart", v); chk("cry_restart", 32'(v), 32'b01000);
    chk("cnt_after_cry", 32'(response_count), 7);

    // KICK_LEGS captured then changed to EAT during WAIT: abort, nothing counted.
    action = 8'h01;
    wait_idle("idle_before_kick");
    action = 8'h20;
    @(negedge clk);
    chk("kick_busy", 32'(busy), 1);
    action = 8'h02;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_cnt",  32'(response_count), 7);
    repeat (12) @(negedge clk);
    chk("eat_stim", 32'(stimuli_out), 0);
    chk("eat_busy", 32'(busy), 0);
    chk("eat_cnt",  32'(response_count), 7);

    // enable dropped mid-pulse: pulse still lasts its full length.
    action = 8'h08;
    n = 0;
    do begin @(negedge clk); n++; end while (stimuli_out == 5'd0 && n < 40);
    if (stimuli_out == 5'd0) tmo("pulse_en_drop");
    enable = 1'b0;
    @(negedge clk);
    chk("endrop_hold", 32'(stimuli_out), 32'b00001);
    @(negedge clk);
    chk("endrop_end",  32'(stimuli_out), 0);
    chk("endrop_cnt",  32'(response_count), 8);
    enable = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (stimuli_out == 5'd0 && n < 40);
    if (stimuli_out == 5'd0) tmo("pulse_before_rst");
    chk("pre_rst_cnt", 32'(response_count), 9);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_stim",  32'(stimuli_out),    0);
    chk("midrst_busy",  32'(busy),           0);
    chk("midrst_count", 32'(response_count), 0);

    // Invalid actions set a sticky error and are never captured.
    rst_n = 1'b1; action = 8'h0C;
    @(negedge clk);
    chk("err_set",  32'(onehot_err), 1);
    chk("err_busy", 32'(busy), 0);
    action = 8'h00;
    @(negedge clk);
    chk("err_zero", 32'(onehot_err), 1);
    action = 8'h01;
    repeat (3) @(negedge clk);
    chk("err_sticky", 32'(onehot_err), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("err_clear", 32'(onehot_err), 0);
    rst_n = 1'b1;

    // Randomized traffic, checked cycle-by-cycle by the model.
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (hold == 0) begin
        r = $urandom_range(0, 99);
        if (r < 75)      action = 8'h01 << $urandom_range(0, 7);
        else if (r < 85) action = 8'h00;
        else             action = 8'($urandom);
        hold = $urandom_range(1, 25);
        enable = ($urandom_range(0, 9) != 0);
      end else begin
        hold--;
      end
      if ($urandom_range(0, 39) == 0) enable = !enable;
      rst_n = ($urandom_range(0, 399) != 0);
    end

    // 256 SMILE responses: capture-to-pulse delay and saturation.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; action = 8'h08; enable = 1'b1;
    lo = RD;
    hi = JIT ? RD + 3 : RD;
    for (int p = 0; p < 256; p++) begin
      wait_idle("sat_idle");
      n = 0;
      do begin @(negedge clk); n++; end while (stimuli_out == 5'd0 && n < 40);
      dly = n - 1;
      total++;
      if (stimuli_out == 5'd0 || dly < lo || dly > hi) begin
        bad++;
        $display("FAIL sat_delay pulse %0d: delay=%0d required %0d..%0d", p, dly, lo, hi);
      end
    end
    repeat (2) @(negedge clk);
    chk("sat_count", 32'(response_count), 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
